// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MdOp_In operation encodings
//   - operation latencies (MULT_LAT, DIV_LAT) and counter width
//   - two-state FSM enum
//   - small decode helpers used by the top level
// Optional feature macro: MDU_DIV_EN (enables div/divu).
package mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MULT_LAT = 4'd5;
  localparam logic [CNT_W-1:0] DIV_LAT  = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational result datapath.
//   op     : captured operation (mult/multu/div/divu)
//   src_a  : captured rs operand
//   src_b  : captured rt operand
//   result : {hi, lo}; product for mult ops, {remainder, quotient} for div ops.
// Divide datapath exists only when MDU_DIV_EN is defined.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result
);

  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;

  // Sign/zero extension to 64 bits makes the truncated 64-bit product exact.
  assign prod_s_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u_s = {32'd0, src_a} * {32'd0, src_b};

`ifdef MDU_DIV_EN
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] sq_s;
  logic [31:0] sr_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;

  // Signed divide via magnitudes: 0x80000000 has magnitude 0x80000000 when
  // read unsigned, so the overflow case falls out as q=0x80000000, r=0.
  assign mag_a_s = src_a[31] ? (32'd0 - src_a) : src_a;
  assign mag_b_s = src_b[31] ? (32'd0 - src_b) : src_b;
  // Zero divisor guarded so no X reaches the result; the top never commits it.
  assign q_mag_s = (mag_b_s == 32'd0) ? 32'd0 : (mag_a_s / mag_b_s);
  assign r_mag_s = (mag_b_s == 32'd0) ? 32'd0 : (mag_a_s % mag_b_s);
  assign sq_s    = (src_a[31] ^ src_b[31]) ? (32'd0 - q_mag_s) : q_mag_s;
  assign sr_s    = src_a[31] ? (32'd0 - r_mag_s) : r_mag_s;
  assign uq_s    = (src_b == 32'd0) ? 32'd0 : (src_a / src_b);
  assign ur_s    = (src_b == 32'd0) ? 32'd0 : (src_a % src_b);
`endif

  // Result select by captured operation.
  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = prod_s_s;
      OP_MULTU: result = prod_u_s;
`ifdef MDU_DIV_EN
      OP_DIV:   result = {sr_s, sq_s};
      OP_DIVU:  result = {ur_s, uq_s};
`endif
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit.
//   Clk_In   : clock, rising edge
//   Reset_In : asynchronous active-high reset
//   Start_In : operation request, sampled on rising edge
//   MdOp_In  : operation (none/mult/multu/div/divu/mthi/mtlo/reserved)
//   SrcA_In  : rs operand (also mthi/mtlo data)
//   SrcB_In  : rt operand
//   Busy_Out : high while a mult/div is in flight
//   Hi_Out   : HI register
//   Lo_Out   : LO register
// Feature macro MDU_DIV_EN: when undefined, div/divu are treated as no-ops.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        Clk_In,
  input  logic        Reset_In,
  input  logic        Start_In,
  input  logic [2:0]  MdOp_In,
  input  logic [31:0] SrcA_In,
  input  logic [31:0] SrcB_In,
  output logic        Busy_Out,
  output logic [31:0] Hi_Out,
  output logic [31:0] Lo_Out
);

  mdu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [2:0]       op_r;
  logic [31:0]      a_r;
  logic [31:0]      b_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;

  logic             launch_s;
  logic [CNT_W-1:0] lat_s;
  logic             skip_commit_s;
  logic [63:0]      calc_s;

  mdu_calc u_calc (
    .op     (op_r),
    .src_a  (a_r),
    .src_b  (b_r),
    .result (calc_s)
  );

`ifdef MDU_DIV_EN
  assign launch_s      = is_mult(MdOp_In) || is_div(MdOp_In);
  assign skip_commit_s = is_div(op_r) && (b_r == 32'd0);
`else
  assign launch_s      = is_mult(MdOp_In);
  assign skip_commit_s = 1'b0;
`endif
  assign lat_s = is_mult(MdOp_In) ? MULT_LAT : DIV_LAT;

  // FSM, counter, operand capture and HI/LO registers. done_r marks the
  // cycle in which Busy_Out has just fallen; starts sampled then are dropped.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      op_r    <= OP_NONE;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start_In && !done_r) begin
            if (launch_s) begin
              state_r <= RUN;
              cnt_r   <= lat_s;
              busy_r  <= 1'b1;
              op_r    <= MdOp_In;
              a_r     <= SrcA_In;
              b_r     <= SrcB_In;
            end else if (MdOp_In == OP_MTHI) begin
              hi_r <= SrcA_In;
            end else if (MdOp_In == OP_MTLO) begin
              lo_r <= SrcA_In;
            end else begin
              hi_r <= hi_r;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (cnt_r == 4'd1) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            if (!skip_commit_s) begin
              hi_r <= calc_s[63:32];
              lo_r <= calc_s[31:0];
            end else begin
              hi_r <= hi_r;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy_Out = busy_r;
  assign Hi_Out   = hi_r;
  assign Lo_Out   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
// Division tests run when MDU_DIV_EN is defined; otherwise div/divu are
// checked to be no-ops.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        Clk_In;
  logic        Reset_In;
  logic        Start_In;
  logic [2:0]  MdOp_In;
  logic [31:0] SrcA_In;
  logic [31:0] SrcB_In;
  logic        Busy_Out;
  logic [31:0] Hi_Out;
  logic [31:0] Lo_Out;

  int total;
  int bad;

  mult_div_unit dut (
    .Clk_In   (Clk_In),
    .Reset_In (Reset_In),
    .Start_In (Start_In),
    .MdOp_In  (MdOp_In),
    .SrcA_In  (SrcA_In),
    .SrcB_In  (SrcB_In),
    .Busy_Out (Busy_Out),
    .Hi_Out   (Hi_Out),
    .Lo_Out   (Lo_Out)
  );

  initial Clk_In = 1'b0;
  always #5 Clk_In = ~Clk_In;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  // Present a start for one edge, then drop it and scramble the operands.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start_In = 1'b1;
    MdOp_In  = op;
    SrcA_In  = a;
    SrcB_In  = b;
    tick();
    Start_In = 1'b0;
    MdOp_In  = OP_NONE;
    SrcA_In  = 32'hA5A5_5A5A;
    SrcB_In  = 32'h0000_0000;
  endtask

  // Count busy cycles from now until Busy_Out drops (bounded).
  task automatic wait_busy(output int n);
    n = 0;
    while (Busy_Out && n < 30) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    Reset_In = 1'b1;
    Start_In = 1'b0;
    MdOp_In  = OP_NONE;
    SrcA_In  = 32'd0;
    SrcB_In  = 32'd0;
    tick();
    tick();
    total++; if (Busy_Out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", Busy_Out); end
    total++; if (Hi_Out !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", Hi_Out); end
    total++; if (Lo_Out !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", Lo_Out); end
    Reset_In = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int n;
    launch(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_busy(n);
    total++; if (n !== 5) begin bad++; $display("FAIL mult_busy got=%0d want=5", n); end
    total++; if (Hi_Out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", Hi_Out); end
    total++; if (Lo_Out !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h want=fffffffa", Lo_Out); end
    tick();
    launch(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_busy(n);
    total++; if (n !== 5) begin bad++; $display("FAIL multu_busy got=%0d want=5", n); end
    total++; if (Hi_Out !== 32'h0000_0002) begin bad++; $display("FAIL multu_hi got=%h want=00000002", Hi_Out); end
    total++; if (Lo_Out !== 32'hFFFF_FFFA) begin bad++; $display("FAIL multu_lo got=%h want=fffffffa", Lo_Out); end
    tick();
  endtask

  task automatic test_mthi_mtlo();
    int n;
    launch(OP_MTHI, 32'h1234_5678, 32'd0);
    total++; if (Hi_Out !== 32'h1234_5678) begin bad++; $display("FAIL mthi_hi got=%h want=12345678", Hi_Out); end
    total++; if (Busy_Out !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b want=0", Busy_Out); end
    launch(OP_MULT, 32'd2, 32'd3);
    total++; if (Busy_Out !== 1'b1) begin bad++; $display("FAIL mult_started got=%0b want=1", Busy_Out); end
    // mtlo while busy must be dropped
    launch(OP_MTLO, 32'h0000_DEAD, 32'd0);
    wait_busy(n);
    total++; if (n + 1 !== 5) begin bad++; $display("FAIL busy_mtlo_busy got=%0d want=5", n + 1); end
    total++; if (Lo_Out !== 32'd6) begin bad++; $display("FAIL busy_mtlo_lo got=%h want=00000006", Lo_Out); end
    total++; if (Hi_Out !== 32'd0) begin bad++; $display("FAIL busy_mtlo_hi got=%h want=0", Hi_Out); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    launch(OP_MULT, 32'd4, 32'd5);
    wait_busy(n);
    total++; if (Lo_Out !== 32'd20) begin bad++; $display("FAIL b2b_first_lo got=%h want=00000014", Lo_Out); end
    // Start in the cycle Busy_Out fell: ignored.
    Start_In = 1'b1;
    MdOp_In  = OP_MULT;
    SrcA_In  = 32'd7;
    SrcB_In  = 32'd7;
    tick();
    total++; if (Busy_Out !== 1'b0) begin bad++; $display("FAIL b2b_ignored_busy got=%0b want=0", Busy_Out); end
    // Held one more cycle: launches.
    launch(OP_MULT, 32'd7, 32'd7);
    wait_busy(n);
    total++; if (n !== 5) begin bad++; $display("FAIL b2b_second_busy got=%0d want=5", n); end
    total++; if (Lo_Out !== 32'd49) begin bad++; $display("FAIL b2b_second_lo got=%h want=00000031", Lo_Out); end
    tick();
  endtask

  task automatic test_noop();
    launch(OP_RSVD, 32'h1111_1111, 32'h2222_2222);
    total++; if (Busy_Out !== 1'b0) begin bad++; $display("FAIL rsvd_busy got=%0b want=0", Busy_Out); end
    launch(OP_NONE, 32'h1111_1111, 32'h2222_2222);
    repeat (6) tick();
    total++; if (Lo_Out !== 32'd49) begin bad++; $display("FAIL noop_lo got=%h want=00000031", Lo_Out); end
    total++; if (Hi_Out !== 32'd0) begin bad++; $display("FAIL noop_hi got=%h want=0", Hi_Out); end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    int n;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_busy(n);
    total++; if (n !== 10) begin bad++; $display("FAIL div_busy got=%0d want=10", n); end
    total++; if (Lo_Out !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", Lo_Out); end
    total++; if (Hi_Out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", Hi_Out); end
    tick();
    launch(OP_DIVU, 32'd7, 32'd0);
    wait_busy(n);
    total++; if (n !== 10) begin bad++; $display("FAIL divz_busy got=%0d want=10", n); end
    total++; if (Lo_Out !== 32'hFFFF_FFFD) begin bad++; $display("FAIL divz_lo got=%h want=fffffffd", Lo_Out); end
    total++; if (Hi_Out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_hi got=%h want=ffffffff", Hi_Out); end
    tick();
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(n);
    total++; if (Lo_Out !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo got=%h want=80000000", Lo_Out); end
    total++; if (Hi_Out !== 32'd0) begin bad++; $display("FAIL divovf_hi got=%h want=0", Hi_Out); end
    tick();
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_busy(n);
    total++; if (Lo_Out !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h want=0000000e", Lo_Out); end
    total++; if (Hi_Out !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h want=00000002", Hi_Out); end
    tick();
  endtask
`else
  task automatic test_div_disabled();
    launch(OP_MTHI, 32'hAAAA_0000, 32'd0);
    launch(OP_MTLO, 32'h0000_5555, 32'd0);
    launch(OP_DIV, 32'd8, 32'd2);
    total++; if (Busy_Out !== 1'b0) begin bad++; $display("FAIL nodiv_busy got=%0b want=0", Busy_Out); end
    launch(OP_DIVU, 32'd8, 32'd2);
    total++; if (Busy_Out !== 1'b0) begin bad++; $display("FAIL nodivu_busy got=%0b want=0", Busy_Out); end
    repeat (12) tick();
    total++; if (Hi_Out !== 32'hAAAA_0000) begin bad++; $display("FAIL nodiv_hi got=%h want=aaaa0000", Hi_Out); end
    total++; if (Lo_Out !== 32'h0000_5555) begin bad++; $display("FAIL nodiv_lo got=%h want=00005555", Lo_Out); end
  endtask
`endif

  task automatic test_reset_abort();
    int n;
`ifdef MDU_DIV_EN
    launch(OP_DIV, 32'd100, 32'd3);
`else
    launch(OP_MULT, 32'd100, 32'd3);
`endif
    tick();
    tick();
    Reset_In = 1'b1;
    #2;
    total++; if (Busy_Out !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", Busy_Out); end
    total++; if (Hi_Out !== 32'd0) begin bad++; $display("FAIL abort_hi got=%h want=0", Hi_Out); end
    total++; if (Lo_Out !== 32'd0) begin bad++; $display("FAIL abort_lo got=%h want=0", Lo_Out); end
    Reset_In = 1'b0;
    repeat (14) tick();
    total++; if (Lo_Out !== 32'd0) begin bad++; $display("FAIL abort_nocommit_lo got=%h want=0", Lo_Out); end
    total++; if (Busy_Out !== 1'b0) begin bad++; $display("FAIL abort_nocommit_busy got=%0b want=0", Busy_Out); end
    launch(OP_MULT, 32'd3, 32'd4);
    wait_busy(n);
    total++; if (n !== 5) begin bad++; $display("FAIL post_reset_busy got=%0d want=5", n); end
    total++; if (Lo_Out !== 32'd12) begin bad++; $display("FAIL post_reset_lo got=%h want=0000000c", Lo_Out); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mult();
    test_mthi_mtlo();
    test_back_to_back();
    test_noop();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-high.
REQ-002 The port Clk_In SHALL be an input, 1 bit wide, and serve as the clock; all state updates on its rising edge.
REQ-003 The port Reset_In SHALL be an input, 1 bit wide, and act as the asynchronous active-high reset.
REQ-004 The port Start_In SHALL be an input, 1 bit wide, and request the operation on MdOp_In, sampled on a rising edge.
REQ-005 The port MdOp_In SHALL be an input, 3 bits wide, with encoding 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, and 7 reserved, treated as none.
REQ-006 The ports SrcA_In and SrcB_In SHALL each be an input, 32 bits wide; they are the rs and rt operands.
REQ-007 The port Busy_Out SHALL be an output, 1 bit wide, and be high while a mult or div is in flight.
REQ-008 The ports Hi_Out and Lo_Out SHALL each be an output, 32 bits wide, and be driven directly from the HI and LO registers.

Function
REQ-009 Start_In=1 with mult or multu SHALL launch an operation with latency MULT_LAT=5; div or divu SHALL use DIV_LAT=10.
REQ-010 The operands SHALL be captured at the launch edge; later changes to SrcA_In or SrcB_In SHALL have no effect on the result.
REQ-011 If launch occurs at edge k, Busy_Out SHALL be high for cycles k+1 through k+LAT, and the new HI and LO SHALL be visible from edge k+LAT, in the same cycle that Busy_Out falls.
REQ-012 mult SHALL produce the signed 64-bit product and multu the unsigned one, with HI={prod[63:32]} and LO={prod[31:0]}.
REQ-013 div and divu SHALL set LO=quotient and HI=remainder, truncating toward zero, with the remainder taking the sign of the dividend for div.
REQ-014 For a divisor of 0 (div or divu), the block SHALL run the full DIV_LAT busy period and leave HI and LO unchanged.
REQ-015 For div, the case 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-016 mthi or mtlo with Start_In=1 and Busy_Out=0 SHALL write SrcA_In into HI or LO at the same edge, without asserting Busy_Out.
REQ-017 Any Start_In (any op) while Busy_Out=1 SHALL be ignored, leaving in-flight state, the counter, and HI/LO unaffected.
REQ-018 A Start_In in the cycle Busy_Out falls SHALL be treated as Busy_Out=1 and ignored; back-to-back launch is only allowed from the next cycle.
REQ-019 Start_In with op none or reserved SHALL be a no-op.
REQ-020 The internal state machine SHALL have two states: IDLE and RUN. IDLE goes to RUN on a valid mult/div launch; RUN goes to IDLE when the down-counter reaches 1, at which point the result is committed.

Reset
REQ-021 On Reset_In=1, the block SHALL asynchronously clear HI, LO, the counter, and the pending result registers to 0, and set the state to IDLE and Busy_Out to 0.
REQ-022 A reset asserted mid-operation SHALL abort it with no commit; after reset, the first valid Start_In SHALL behave as in REQ-011.

Configuration
REQ-023 The feature macro SHALL be named MDU_DIV_EN.
REQ-024 With MDU_DIV_EN defined, div and divu SHALL behave as specified above.
REQ-025 Without MDU_DIV_EN, div and divu SHALL be treated as op none: no Busy_Out, no state change, and no divider logic synthesized.

Structure
REQ-026 A shared package mdu_pkg SHALL hold the MdOp_In encoding constants, MULT_LAT, DIV_LAT, and the 2-state enum.
REQ-027 There SHALL be one sub-module, mdu_calc, that is combinational and computes the 64-bit {hi,lo} from the captured operands and op; mult_div_unit owns the counter, the FSM, and the HI/LO registers.

Verification
REQ-028 The bench SHALL check mult with SrcA=0xFFFFFFFE and SrcB=3: Busy_Out is high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA; the same inputs with multu give HI=0x00000002 and LO=0xFFFFFFFA.
REQ-029 The bench SHALL check div with 0xFFFFFFF9 (-7) by 2: Busy_Out is high for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; divu with 7 by 0 gives 10 busy cycles and HI/LO unchanged.
REQ-030 The bench SHALL check mthi with 0x12345678 while idle, giving Hi_Out=0x12345678 the next cycle; then issue mult 2*3 and, during busy, mtlo 0xDEAD; the mtlo is ignored and LO ends at 6.
REQ-031 The bench SHALL check reset: Reset_In is pulsed at cycle 3 of a div, then Busy_Out=0 and HI=LO=0 immediately, with no later commit.
REQ-032 The bench SHALL check back-to-back launches: a Start_In mult in the Busy_Out falling cycle is ignored, and a Start_In one cycle later launches normally.
REQ-033 The bench SHALL be built without MDU_DIV_EN: div 8/2 then gives Busy_Out=0 and HI/LO unchanged.
